reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 9 +
 rtl/decoder_5_to_32.sv | 27 ++
 rtl/reg_file.sv | 77 +++++++
 tb/tb_reg_file.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared datapath constants for the register file
package reg_file_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int ZERO_REG   = 0;

endpackage : reg_file_pkg

// File: rtl/decoder_5_to_32.sv
// rtl/decoder_5_to_32.sv - one-hot write-enable decoder for the register file
//
// Ports:
//   addr   - write register address
//   en     - write enable; when low the whole vector is zero
//   onehot - one bit per register, bit ZERO_REG is never set
module decoder_5_to_32
  import reg_file_pkg::*;
#(
  parameter int AW = ADDR_WIDTH,
  parameter int NR = 2 ** AW
) (
  input  logic [AW-1:0] addr,
  input  logic          en,
  output logic [NR-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
    // The zero register is hard-wired; it must never see a write strobe.
    onehot[ZERO_REG] = 1'b0;
  end

endmodule : decoder_5_to_32

// File: rtl/reg_file.sv
// rtl/reg_file.sv - two-read, one-write register file with write-first bypass
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   rst_n        - asynchronous active-low reset, clears every register
//   read_reg_1   - read port 1 address (rs)
//   read_reg_2   - read port 2 address (rt)
//   write_reg    - write address (rt/rd select)
//   write_data   - data to write
//   reg_write    - write enable
//   read_data_1  - combinational contents of read_reg_1
//   read_data_2  - combinational contents of read_reg_2
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_reg_1,
  input  logic [ADDR_WIDTH-1:0] read_reg_2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2
);

  localparam int NR = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NR];
  logic [NR-1:0]         write_en;
  logic                  write_live;
  logic                  hit_1;
  logic                  hit_2;

  decoder_5_to_32 #(
    .AW (ADDR_WIDTH),
    .NR (NR)
  ) u_decoder (
    .addr   (write_reg),
    .en     (reg_write),
    .onehot (write_en)
  );

  // Async reset has priority, so an edge arriving while rst_n is low never
  // lands a write. Register 0 is only ever loaded with zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NR; i++) begin
        if (write_en[i]) begin
          regs[i] <= write_data;
        end
      end
    end
  end

  // A write to the zero register is discarded, so it must not bypass either.
  assign write_live = reg_write && (write_reg != ADDR_WIDTH'(ZERO_REG));
  assign hit_1      = write_live && (write_reg == read_reg_1);
  assign hit_2      = write_live && (write_reg == read_reg_2);

  always_comb begin
    read_data_1 = '0;
    read_data_2 = '0;
    if (rst_n) begin
      read_data_1 = hit_1 ? write_data : regs[read_reg_1];
      read_data_2 = hit_2 ? write_data : regs[read_reg_2];
    end
  end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;

  int passed;
  int total;

  logic [31:0] model [32];

  reg_file dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read_reg_1  (read_reg_1),
    .read_reg_2  (read_reg_2),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .reg_write   (reg_write),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and apply the architectural effect of the write that
  // was presented during the cycle.
  task automatic tick();
    @(posedge clk);
    if (rst_n && reg_write && write_reg != 5'd0) model[write_reg] = write_data;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic idle();
    reg_write  = 1'b0;
    write_reg  = 5'd0;
    write_data = 32'h0;
  endtask

  task automatic test_reset();
    // Values while reset is held from time zero, bypass request included.
    write_reg  = 5'd4;
    write_data = 32'hCAFEF00D;
    reg_write  = 1'b1;
    read_reg_1 = 5'd4;
    read_reg_2 = 5'd4;
    #2;
    total++;
    if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
      $display("FAIL reset_bypass rd1=%h rd2=%h expected 00000000", read_data_1, read_data_2);
    end else passed++;
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    // Arbitrary writes, then an asynchronous reset between edges.
    for (int i = 0; i < 20; i++) begin
      write_reg  = 5'($urandom_range(1, 31));
      write_data = $urandom;
      reg_write  = 1'b1;
      tick();
    end
    idle();
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    for (int a = 0; a < 32; a++) begin
      read_reg_1 = 5'(a);
      read_reg_2 = 5'(31 - a);
      #1;
      total++;
      if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
        $display("FAIL reset_clear addr=%0d rd1=%h rd2=%h expected 00000000", a, read_data_1, read_data_2);
      end else passed++;
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) begin
      read_reg_1 = 5'(a);
      #1;
      total++;
      if (read_data_1 !== 32'h0) begin
        $display("FAIL reset_after addr=%0d rd1=%h expected 00000000", a, read_data_1);
      end else passed++;
    end
  endtask

  task automatic test_basic();
    write_reg  = 5'd8;
    write_data = 32'hDEADBEEF;
    reg_write  = 1'b1;
    tick();
    idle();
    read_reg_1 = 5'd8;
    read_reg_2 = 5'd8;
    #2;
    total++;
    if (read_data_1 !== 32'hDEADBEEF || read_data_2 !== 32'hDEADBEEF) begin
      $display("FAIL basic_rw rd1=%h rd2=%h expected deadbeef", read_data_1, read_data_2);
    end else passed++;
    read_reg_2 = 5'd9;
    #1;
    total++;
    if (read_data_2 !== 32'h0) begin
      $display("FAIL basic_neighbour rd2=%h expected 00000000", read_data_2);
    end else passed++;
  endtask

  task automatic test_zero_reg();
    write_reg  = 5'd0;
    write_data = 32'hFFFFFFFF;
    reg_write  = 1'b1;
    read_reg_1 = 5'd0;
    read_reg_2 = 5'd0;
    #2;
    total++;
    if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
      $display("FAIL zero_during rd1=%h rd2=%h expected 00000000", read_data_1, read_data_2);
    end else passed++;
    tick();
    idle();
    #1;
    total++;
    if (read_data_1 !== 32'h0 || read_data_2 !== 32'h0) begin
      $display("FAIL zero_after rd1=%h rd2=%h expected 00000000", read_data_1, read_data_2);
    end else passed++;
  endtask

  task automatic test_bypass();
    write_reg  = 5'd3;
    write_data = 32'h0BADC0DE;
    reg_write  = 1'b1;
    tick();
    write_reg  = 5'd17;
    write_data = 32'h12345678;
    reg_write  = 1'b1;
    read_reg_1 = 5'd17;
    read_reg_2 = 5'd3;
    #2;
    total++;
    if (read_data_1 !== 32'h12345678) begin
      $display("FAIL bypass_port1 rd1=%h expected 12345678", read_data_1);
    end else passed++;
    total++;
    if (read_data_2 !== 32'h0BADC0DE) begin
      $display("FAIL bypass_other rd2=%h expected 0badc0de", read_data_2);
    end else passed++;
    read_reg_2 = 5'd17;
    #1;
    total++;
    if (read_data_2 !== 32'h12345678) begin
      $display("FAIL bypass_both rd2=%h expected 12345678", read_data_2);
    end else passed++;
    tick();
    idle();
    #1;
    total++;
    if (read_data_1 !== 32'h12345678) begin
      $display("FAIL bypass_stored rd1=%h expected 12345678", read_data_1);
    end else passed++;
  endtask

  task automatic test_write_disable();
    write_reg  = 5'd5;
    write_data = 32'h0000000A;
    reg_write  = 1'b1;
    tick();
    write_data = 32'h55;
    reg_write  = 1'b0;
    read_reg_1 = 5'd5;
    read_reg_2 = 5'd5;
    for (int i = 0; i < 3; i++) begin
      #2;
      total++;
      if (read_data_1 !== 32'h0000000A || read_data_2 !== 32'h0000000A) begin
        $display("FAIL wdis_cycle%0d rd1=%h rd2=%h expected 0000000a", i, read_data_1, read_data_2);
      end else passed++;
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    write_reg  = 5'd31;
    write_data = 32'hA5A5A5A5;
    reg_write  = 1'b1;
    read_reg_1 = 5'd31;
    #3;
    rst_n = 1'b0;
    clear_model();
    tick();
    tick();
    reg_write = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (read_data_1 !== 32'h0) begin
      $display("FAIL rstmid_clear rd1=%h expected 00000000", read_data_1);
    end else passed++;
    write_data = 32'h1;
    reg_write  = 1'b1;
    tick();
    idle();
    #1;
    total++;
    if (read_data_1 !== 32'h1) begin
      $display("FAIL rstmid_rewrite rd1=%h expected 00000001", read_data_1);
    end else passed++;
  endtask

  task automatic test_random();
    logic [31:0] exp1;
    logic [31:0] exp2;
    for (int i = 0; i < 300; i++) begin
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      reg_write  = 1'($urandom_range(0, 1));
      read_reg_1 = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg_2 = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      exp1 = model[read_reg_1];
      exp2 = model[read_reg_2];
      if (reg_write && write_reg != 5'd0) begin
        if (read_reg_1 == write_reg) exp1 = write_data;
        if (read_reg_2 == write_reg) exp2 = write_data;
      end
      #2;
      total++;
      if (read_data_1 !== exp1 || read_data_2 !== exp2) begin
        $display("FAIL random_%0d ra1=%0d ra2=%0d rd1=%h rd2=%h expected %h %h",
                 i, read_reg_1, read_reg_2, read_data_1, read_data_2, exp1, exp2);
      end else passed++;
      tick();
    end
    idle();
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst_n      = 1'b0;
    read_reg_1 = 5'd0;
    read_reg_2 = 5'd0;
    idle();
    clear_model();
    test_reset();
    test_basic();
    test_zero_reg();
    test_bypass();
    test_write_disable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_reg_file
